// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP word and MIPS
// instruction field positions used by the stage registers and decode taps.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register {pc, instr, valid} with load, hold and flush.
// Flush and reset both clear to an all-zero bubble; otherwise hold unless load.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = 32'h0;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'h0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem req/ack handshake (req/addr held until ack),
// one-entry skid buffer for acks that land under freeze, and the IF/ID register.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [1:0]  dbg_state
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_q, stale_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_valid_q, skid_valid_d;

  logic        reg_load, reg_flush;
  logic [31:0] ld_pc, ld_instr;
  logic        ld_valid;
  logic [31:0] pc_next;

  assign pc_next = pc_q + 32'(PC_STEP);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_d      = stale_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_valid_d = skid_valid_q;
    reg_load     = 1'b0;
    reg_flush    = 1'b0;
    ld_pc        = 32'h0;
    ld_instr     = NOP;
    ld_valid     = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (br_taken) begin
          pc_d      = br_addr;
          reg_flush = 1'b1;
          if (!imem_ack) begin
            // The in-flight fetch must still complete before redirecting.
            stale_d = pc_q;
            state_d = ST_DISCARD;
          end
        end else if (imem_ack) begin
          pc_d = pc_next;
          if (!freeze) begin
            reg_load = 1'b1;
            ld_pc    = pc_next;
            ld_instr = imem_rdata;
            ld_valid = 1'b1;
          end else begin
            skid_pc_d    = pc_next;
            skid_instr_d = imem_rdata;
            skid_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end else begin
          reg_load = !freeze;
        end
      end

      ST_DISCARD: begin
        if (br_taken) begin
          pc_d      = br_addr;
          reg_flush = 1'b1;
        end else begin
          reg_load = !freeze;
        end
        if (imem_ack) state_d = ST_REQ;
      end

      ST_HOLD: begin
        if (br_taken) begin
          pc_d         = br_addr;
          reg_flush    = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = ST_REQ;
        end else if (!freeze) begin
          reg_load     = 1'b1;
          ld_pc        = skid_pc_q;
          ld_instr     = skid_instr_q;
          ld_valid     = skid_valid_q;
          skid_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      stale_q      <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_q      <= stale_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Handshake: imem_req/imem_addr stay stable until the cycle imem_ack is seen.
  assign imem_req  = !rst && (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DISCARD) ? stale_q : pc_q;
  assign dbg_state = state_q;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (reg_flush),
    .load     (reg_load),
    .pc_in    (ld_pc),
    .instr_in (ld_instr),
    .valid_in (ld_valid),
    .pc_out   (if_id_pc),
    .instr_out(if_id_instr),
    .valid_out(if_id_valid)
  );

  assign rs_addr = if_id_instr[RS_HI:RS_LO];
  assign rt_addr = if_id_instr[RT_HI:RT_LO];

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: a table of per-cycle inputs with
// hand-computed outputs, then reset-in-DISCARD and reset-in-HOLD sequences.
module tb_if_stage;

  localparam logic [1:0] S_REQ = 2'd0;
  localparam logic [1:0] S_DIS = 2'd1;
  localparam logic [1:0] S_HLD = 2'd2;

  logic        clk = 1'b0;
  logic        rst, freeze, br_taken, imem_ack;
  logic [31:0] br_addr, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  rs_addr, rt_addr;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst, frz, br;
    logic [31:0] br_addr;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr, exp_pc, exp_instr;
    logic        exp_valid;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_addr(br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .dbg_state(dbg_state)
  );

  function automatic vec_t mk(input logic r, input logic f, input logic b,
                              input logic [31:0] ba, input logic a, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic [31:0] ep,
                              input logic [31:0] ei, input logic ev, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.br_addr = ba; v.ack = a; v.rdata = rd;
    v.exp_req = er; v.exp_addr = ea; v.exp_pc = ep; v.exp_instr = ei;
    v.exp_valid = ev; v.exp_state = es;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s[%0d]: got %h, want %h", name, idx, got, want);
  endtask

  task automatic apply(input string tag, input int idx, input vec_t v);
    logic [4:0] exp_rs, exp_rt;
    @(negedge clk);
    rst = v.rst; freeze = v.frz; br_taken = v.br; br_addr = v.br_addr;
    imem_ack = v.ack; imem_rdata = v.rdata;
    #2;
    check({tag, ".imem_req"}, idx, {31'b0, imem_req}, {31'b0, v.exp_req});
    if (v.exp_req) check({tag, ".imem_addr"}, idx, imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    exp_rs = v.exp_instr[25:21];
    exp_rt = v.exp_instr[20:16];
    check({tag, ".if_id_pc"}, idx, if_id_pc, v.exp_pc);
    check({tag, ".if_id_instr"}, idx, if_id_instr, v.exp_instr);
    check({tag, ".if_id_valid"}, idx, {31'b0, if_id_valid}, {31'b0, v.exp_valid});
    check({tag, ".rs_addr"}, idx, {27'b0, rs_addr}, {27'b0, exp_rs});
    check({tag, ".rt_addr"}, idx, {27'b0, rt_addr}, {27'b0, exp_rt});
    check({tag, ".state"}, idx, {30'b0, dbg_state}, {30'b0, v.exp_state});
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    //          rst frz br  br_addr       ack rdata          req addr          pc            instr          v  state
    tbl.push_back(mk(1, 0, 1, 32'h0000_0040, 1, 32'h0,        0, 32'h0,        32'h0,        32'h0,         0, S_REQ));
    // zero-latency memory, rdata = addr + 0x100
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h100,      1, 32'h0,        32'h4,        32'h100,       1, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h104,      1, 32'h4,        32'h8,        32'h104,       1, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h108,      1, 32'h8,        32'hC,        32'h108,       1, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h10C,      1, 32'hC,        32'h10,       32'h10C,       1, S_REQ));
    // field decode: rs=10, rt=11
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h014B4820, 1, 32'h10,       32'h14,       32'h014B4820,  1, S_REQ));
    // three-cycle latency: address held, bubbles until the cycle after ack
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h14,       32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h14,       32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'hDEAD0001, 1, 32'h14,       32'h18,       32'hDEAD0001,  1, S_REQ));
    // branch while fetch pending: stale address kept, its data dropped
    tbl.push_back(mk(0, 0, 1, 32'h40,        0, 32'h0,        1, 32'h18,       32'h0,        32'h0,         0, S_DIS));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h18,       32'h0,        32'h0,         0, S_DIS));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'hBAD0BAD0, 1, 32'h18,       32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h140,      1, 32'h40,       32'h44,       32'h140,       1, S_REQ));
    // freeze across an ack: skid, req drops, release from skid
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'hAAAA0000, 1, 32'h44,       32'h44,       32'h140,       1, S_HLD));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h44,       32'h140,       1, S_HLD));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h48,       32'hAAAA0000,  1, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h148,      1, 32'h48,       32'h4C,       32'h148,       1, S_REQ));
    // freeze without ack holds IF/ID
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4C,       32'h4C,       32'h148,       1, S_REQ));
    // branch on the ack cycle drops rdata, stays in REQ
    tbl.push_back(mk(0, 0, 1, 32'h80,        1, 32'h1234,     1, 32'h4C,       32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h180,      1, 32'h80,       32'h84,       32'h180,       1, S_REQ));
    // branch in HOLD beats freeze, skid discarded
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h5555,     1, 32'h84,       32'h84,       32'h180,       1, S_HLD));
    tbl.push_back(mk(0, 1, 1, 32'hC0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h1C0,      1, 32'hC0,       32'hC4,       32'h1C0,       1, S_REQ));
    // second branch in DISCARD: last target wins, stale address unchanged
    tbl.push_back(mk(0, 0, 1, 32'h100,       0, 32'h0,        1, 32'hC4,       32'h0,        32'h0,         0, S_DIS));
    tbl.push_back(mk(0, 0, 1, 32'h200,       0, 32'h0,        1, 32'hC4,       32'h0,        32'h0,         0, S_DIS));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'hBAD1,     1, 32'hC4,       32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h300,      1, 32'h200,      32'h204,      32'h300,       1, S_REQ));
    // PC wrap modulo 2^32
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h9999,     1, 32'h204,      32'h0,        32'h0,         0, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h77,       1, 32'hFFFF_FFFC, 32'h0,       32'h77,        1, S_REQ));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h88,       1, 32'h0,        32'h4,        32'h88,        1, S_REQ));

    for (int i = 0; i < tbl.size(); i++) apply("tbl", i, tbl[i]);

    // reset while in DISCARD: in-flight fetch abandoned
    apply("rst_dis", 0, mk(0, 0, 1, 32'h40, 0, 32'h0,   1, 32'h4, 32'h0, 32'h0,   0, S_DIS));
    apply("rst_dis", 1, mk(1, 0, 0, 32'h0,  1, 32'hBAD, 0, 32'h0, 32'h0, 32'h0,   0, S_REQ));
    apply("rst_dis", 2, mk(0, 0, 0, 32'h0,  1, 32'h100, 1, 32'h0, 32'h4, 32'h100, 1, S_REQ));

    // reset while in HOLD: skid contents lost
    apply("rst_hld", 0, mk(0, 1, 0, 32'h0,  1, 32'h104, 1, 32'h4, 32'h4, 32'h100, 1, S_HLD));
    apply("rst_hld", 1, mk(1, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0, 32'h0, 32'h0,   0, S_REQ));
    apply("rst_hld", 2, mk(0, 0, 0, 32'h0,  1, 32'h100, 1, 32'h0, 32'h4, 32'h100, 1, S_REQ));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request/acknowledge handshake, one-entry skid buffer, and the IF/ID pipeline register.
- Its IF/ID outputs feed decode. The rs and rt fields drive the register file's src1 and src2 read addresses directly.
- Handles variable-latency instruction memory, hazard freeze, and taken-branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall from hazard unit; IF/ID holds.
- br_taken  in  1  taken-branch redirect from decode.
- br_addr  in  32  branch target byte address.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch byte address; stable while imem_req=1 until imem_ack.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- if_id_pc  out  32  address of the IF/ID instruction plus PC_STEP.
- if_id_instr  out  32  instruction; 0 (NOP) when bubble.
- if_id_valid  out  1  IF/ID holds a real instruction.
- rs_addr  out  5  if_id_instr[25:21]; feeds register file src1.
- rt_addr  out  5  if_id_instr[20:16]; feeds register file src2.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc=RESET_PC, state=REQ, skid empty.
  - if_id_pc=0, if_id_instr=0, if_id_valid=0.
  - imem_req forced 0 while rst=1.
  - rst overrides every other input; an in-flight fetch is abandoned. The memory must tolerate this by reset-sharing.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - DISCARD: imem_req=1, imem_addr=stale_addr.
  - HOLD: imem_req=0.
- REQ, no ack:
  - IF/ID loads a bubble unless freeze=1, in which case it holds.
  - br_taken=1: stale_addr<=pc, pc<=br_addr, IF/ID flushed, go to DISCARD.
- REQ, ack:
  - br_taken=1: drop rdata, pc<=br_addr, IF/ID flushed, stay in REQ.
  - Else freeze=0: IF/ID<={pc+PC_STEP, rdata, valid=1}, pc<=pc+PC_STEP, stay in REQ.
  - Else freeze=1: skid<={pc+PC_STEP, rdata}, pc<=pc+PC_STEP, IF/ID holds, go to HOLD.
- DISCARD:
  - Waits for ack; the acked data is dropped, then go to REQ.
  - A further br_taken overwrites pc only; stale_addr is kept.
  - IF/ID loads a bubble, or holds under freeze; br_taken flushes.
- HOLD:
  - br_taken=1: skid cleared, pc<=br_addr, IF/ID flushed, go to REQ.
  - Else freeze=0: IF/ID<=skid with valid=1, go to REQ.
  - Else: hold.
- Priority: rst > br_taken > freeze. Flush means if_id_instr=0, if_id_valid=0, if_id_pc=0.
- Latency: minimum one instruction per cycle when imem_ack arrives the same cycle as the request. Instruction data appears on IF/ID the cycle after ack.
- Arithmetic: PC adds wrap modulo 2^32; no alignment check. br_addr is used verbatim.

Decomposition:
- Shared package, pipeline_pkg:
  - state encoding (REQ/DISCARD/HOLD);
  - NOP constant 32'h0;
  - instruction field bit positions (RS_HI/LO, RT_HI/LO).
- One natural sub-module, if_id_reg: the IF/ID register with load, hold and flush controls. Reused by the pipeline's other stage registers.

Test Plan:
- Reset then zero-latency memory (ack in the same cycle as req, rdata=addr+32'h100), freeze=0 for 4 cycles:
  - imem_addr = 0, 4, 8, C;
  - IF/ID shows {4, 0x100}, {8, 0x104}, ..., valid=1 each cycle.
- Instruction word 0x014B4820 accepted:
  - next cycle rs_addr=10, rt_addr=11.
- Three-cycle memory latency:
  - imem_addr stays 0 for 3 cycles;
  - IF/ID valid=0 until the cycle after ack.
- br_taken with br_addr=0x40 while a fetch of 0x8 is pending:
  - imem_addr stays 0x8 until ack and that data never reaches IF/ID;
  - the next request addresses 0x40;
  - IF/ID flushed in the br_taken cycle.
- freeze=1 across an ack of 0xAAAA0000 at pc 0x10:
  - IF/ID holds the prior instruction and imem_req drops;
  - on freeze=0, IF/ID={0x14, 0xAAAA0000} and the next request is 0x14.
- rst asserted in DISCARD and in HOLD:
  - next cycle pc=RESET_PC, all IF/ID outputs 0, state REQ;
  - imem_req=0 during rst.
